gb_cpu_mcycle_sequencer: RTL
============================

# gb_cpu_mcycle_sequencer

Parametrised M-cycle sequencer that drives decoded instruction schedules through time. It holds the instruction register (IR) and the CB-prefix flag, and counts T-cycles and M-cycles. It selects the per-M-cycle control word from the decoder's flattened schedule, and handles conditional early termination, fetch/execute overlap, and HALT/wake. It sits between the memory fetch path and `gb_cpu_decoder`: IR and `cb_prefix` feed the decoder, and the decoder's schedule feeds back into this block.

## Interface
Parameters:
- `MAX_MCYCLES`, 6: maximum M-cycles per instruction.
- `TCYCLES_PER_M`, 4: T-cycles per M-cycle; must be ≥2.
- `CTRL_W`, 32: width of one M-cycle control word.

Derived widths:
- `MW = $clog2(MAX_MCYCLES+1)`
- `TW = $clog2(TCYCLES_PER_M)`

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `tick_en`  in  1  T-cycle advance enable.
- `opcode_in`  in  8  bus data; valid at the final T-cycle of a fetch M-cycle.
- `sched_ctrl`  in  MAX_MCYCLES*CTRL_W  control words; M-cycle k occupies bits [k*CTRL_W +: CTRL_W].
- `sched_len`  in  MW  instruction length in M-cycles.
- `sched_cond_idx`  in  MW  1-based M-cycle whose end samples `cond_met`; 0 means unconditional.
- `cond_met`  in  1  branch condition result from the flag unit.
- `halt_req`  in  1  current instruction is HALT.
- `irq_pending`  in  1  interrupt pending (wake source).
- `ir`  out  8  instruction register, to the decoder.
- `cb_prefix`  out  1  current IR is a CB-page opcode.
- `ctrl_word`  out  CTRL_W  active M-cycle control word.
- `mcycle`  out  MW  current M-cycle index.
- `tcycle`  out  TW  current T-cycle index.
- `m_boundary`  out  1  high during the last T-cycle of an M-cycle while `tick_en` is high.
- `instr_done`  out  1  `m_boundary` of an instruction's final M-cycle.
- `halted`  out  1  in the HALT state.

## Operation
- States: `S_BOOT`, `S_EXEC`, `S_HALT`.
- Reset:
  - state `S_BOOT`; `ir` = 8'h00; `cb_prefix` = 0; `mcycle` = 0; `tcycle` = 0.
  - `halted` = 0.
  - `ctrl_word` = 0; `m_boundary` = 0; `instr_done` = 0.
- `tcycle` increments on `tick_en`; it wraps to 0 after `TCYCLES_PER_M-1`. All other state changes happen only at `m_boundary`.
- `S_BOOT`: `ctrl_word` = 0. At the first boundary, IR ← `opcode_in` and the state moves to `S_EXEC` with `mcycle` = 0.
- `S_EXEC`: `ctrl_word` = `sched_ctrl` slice [`mcycle`].
  - Effective length L = clamp(`sched_len`, 1, `MAX_MCYCLES`).
- At a boundary in `S_EXEC`, apply the first matching rule in this order:
  1. `mcycle` = L−1 (final M-cycle, which overlaps the next fetch): assert `instr_done`; set `mcycle` ← 0.
     - If `halt_req` is high: go to `S_HALT` and leave IR unchanged.
     - Otherwise: IR ← `opcode_in`, and `cb_prefix` ← (old IR = 8'hCB && !old `cb_prefix`).
  2. `sched_cond_idx` ≠ 0, `mcycle` = `sched_cond_idx`−1, and `cond_met` = 0: `mcycle` ← L−1. The remaining M-cycles are skipped and the final fetch cycle still executes.
  3. Otherwise: `mcycle` ← `mcycle`+1.
- `S_HALT`:
  - `halted` = 1, `ctrl_word` = 0, `mcycle` = 0.
  - At a boundary with `irq_pending` = 1: IR ← `opcode_in`, `cb_prefix` ← 0, go to `S_EXEC`.
  - `halt_req` is ignored in this state.
- A CB prefix byte is an ordinary 1-M-cycle instruction. Back-to-back 8'hCB bytes: the second byte is a CB-page opcode, not another prefix.

## Timing
- Output registers: `ir`, `cb_prefix`, state, `mcycle`, `tcycle`. The decoder is combinational from `ir`/`cb_prefix`, so the schedule is stable within one clock of an IR load.
- Combinational outputs: `ctrl_word`, `m_boundary`, `instr_done`.
- Instruction latency is L × `TCYCLES_PER_M` enabled ticks, or (`sched_cond_idx`+1) × `TCYCLES_PER_M` when the condition fails.
- Gating: `tick_en` = 0 freezes every register. `m_boundary` and `instr_done` are gated by `tick_en`.
- A failing condition in the final M-cycle (`sched_cond_idx` = L) has no effect; rule 1 wins.
- `sched_cond_idx` > L is treated as unconditional.
- An asynchronous reset mid-instruction aborts immediately. After release, the first fetch takes one full M-cycle in `S_BOOT`.

## Structure
- Add to `gb_cpu_common_pkg`:
  - `seq_state_t` enum (`S_BOOT`, `S_EXEC`, `S_HALT`).
  - `localparam CB_PREFIX_OPCODE = 8'hCB`.
- The schedule packing helpers stay in `gb_cpu_decoder_pkg`, alongside the existing schedule functions.
- Sub-module `gb_cpu_tcycle_counter`: the enabled modulo-N counter that produces `tcycle` and `m_boundary`.
- `gb_cpu_decoder` is instantiated by the CPU top, not inside this block.

## Test plan
1. Reset release, `tick_en` = 1, `opcode_in` = 8'h00, `sched_len` = 1 → first `m_boundary` after 4 clocks; IR = 00; `instr_done` then pulses every 4 clocks.
2. `sched_len` = 3, unconditional, distinct control words A/B/C → `ctrl_word` = A, B, C for 4 clocks each; `instr_done` only at clock 12.
3. `sched_len` = 3, `sched_cond_idx` = 1, `cond_met` = 0 → `mcycle` sequence 0, 2; `instr_done` after 8 clocks. With `cond_met` = 1 → 0, 1, 2 (12 clocks).
4. `opcode_in` = CB, then CB, then 37 → `cb_prefix` values 0, 1, 0 on successive instructions.
5. `halt_req` = 1 at final boundary → `halted` = 1, `ctrl_word` = 0; raise `irq_pending` after 20 clocks → exit at the next boundary with IR = `opcode_in`.
6. Toggle `tick_en` 1/0 → all timings double. Assert `rst_n` = 0 at `mcycle` = 1 → all outputs at reset values immediately.

Source files
------------

// File: rtl/gb_cpu_common_pkg.sv
// gb_cpu_common_pkg: types and constants shared across the CPU core
// Holds the M-cycle sequencer state encoding and the CB page prefix opcode.
package gb_cpu_common_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_EXEC,
        S_HALT
    } seq_state_t;

    localparam logic [7:0] CB_PREFIX_OPCODE = 8'hCB;

endpackage

// File: rtl/gb_cpu_tcycle_counter.sv
// gb_cpu_tcycle_counter: enabled modulo-N T-cycle counter with M-cycle boundary strobe
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   tick_en     advance enable
//   tcycle      current T-cycle index, wraps after N-1
//   m_boundary  high on the last T-cycle while tick_en is high
module gb_cpu_tcycle_counter #(
    parameter int N  = 4,
    parameter int TW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick_en,
    output logic [TW-1:0] tcycle,
    output logic          m_boundary
);

    logic last_t;

    assign last_t     = tcycle == TW'(N - 1);
    assign m_boundary = tick_en && last_t;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            tcycle <= '0;
        else if (tick_en)
            tcycle <= last_t ? '0 : tcycle + 1'b1;

endmodule

// File: rtl/gb_cpu_mcycle_sequencer.sv
// gb_cpu_mcycle_sequencer: steps decoded instruction schedules through M-cycles
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   tick_en          T-cycle advance enable; low freezes all state
//   opcode_in        fetched byte, sampled at the final T-cycle of a fetch M-cycle
//   sched_ctrl       flattened per-M-cycle control words from the decoder
//   sched_len        instruction length in M-cycles (clamped to 1..MAX_MCYCLES)
//   sched_cond_idx   1-based M-cycle whose end samples cond_met; 0 = unconditional
//   cond_met         branch condition result
//   halt_req         current instruction is HALT
//   irq_pending      wake source while halted
//   ir, cb_prefix    instruction register and CB page flag, to the decoder
//   ctrl_word        active control word (zero outside S_EXEC)
//   mcycle, tcycle   current M-cycle and T-cycle indices
//   m_boundary       last T-cycle of an M-cycle with tick_en high
//   instr_done       boundary of an instruction's final M-cycle
//   halted           in the HALT state
module gb_cpu_mcycle_sequencer
    import gb_cpu_common_pkg::*;
#(
    parameter  int MAX_MCYCLES   = 6,
    parameter  int TCYCLES_PER_M = 4,
    parameter  int CTRL_W        = 32,
    localparam int MW            = $clog2(MAX_MCYCLES + 1),
    localparam int TW            = $clog2(TCYCLES_PER_M)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tick_en,
    input  logic [7:0]                    opcode_in,
    input  logic [MAX_MCYCLES*CTRL_W-1:0] sched_ctrl,
    input  logic [MW-1:0]                 sched_len,
    input  logic [MW-1:0]                 sched_cond_idx,
    input  logic                          cond_met,
    input  logic                          halt_req,
    input  logic                          irq_pending,
    output logic [7:0]                    ir,
    output logic                          cb_prefix,
    output logic [CTRL_W-1:0]             ctrl_word,
    output logic [MW-1:0]                 mcycle,
    output logic [TW-1:0]                 tcycle,
    output logic                          m_boundary,
    output logic                          instr_done,
    output logic                          halted
);

    seq_state_t          state;
    logic [MW-1:0]       eff_len;
    logic [MW-1:0]       last_idx;
    logic                last_m;
    logic                cond_fail;
    logic [CTRL_W-1:0]   words [2**MW];

    gb_cpu_tcycle_counter #(
        .N  (TCYCLES_PER_M),
        .TW (TW)
    ) u_tcnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_en    (tick_en),
        .tcycle     (tcycle),
        .m_boundary (m_boundary)
    );

    // Padded to a power of two so any mcycle value indexes a defined word.
    for (genvar k = 0; k < 2**MW; k++) begin : g_words
        if (k < MAX_MCYCLES) begin : g_live
            assign words[k] = sched_ctrl[k*CTRL_W +: CTRL_W];
        end else begin : g_pad
            assign words[k] = '0;
        end
    end

    always_comb begin
        eff_len   = sched_len == '0 ? MW'(1) :
                    sched_len > MW'(MAX_MCYCLES) ? MW'(MAX_MCYCLES) : sched_len;
        last_idx  = eff_len - MW'(1);
        last_m    = mcycle == last_idx;
        // A condition index beyond the instruction length is unconditional.
        cond_fail = sched_cond_idx != '0 && sched_cond_idx <= eff_len &&
                    mcycle == sched_cond_idx - MW'(1) && !cond_met;
    end

    assign ctrl_word  = state == S_EXEC ? words[mcycle] : '0;
    assign instr_done = m_boundary && state == S_EXEC && last_m;
    assign halted     = state == S_HALT;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= S_BOOT;
            ir        <= 8'h00;
            cb_prefix <= 1'b0;
            mcycle    <= '0;
        end else if (m_boundary) begin
            case (state)
                S_BOOT: begin
                    ir        <= opcode_in;
                    cb_prefix <= 1'b0;
                    mcycle    <= '0;
                    state     <= S_EXEC;
                end
                S_EXEC: begin
                    if (last_m) begin
                        mcycle <= '0;
                        if (halt_req)
                            state <= S_HALT;
                        else begin
                            ir        <= opcode_in;
                            // A CB byte fetched as a CB-page opcode is not a new prefix.
                            cb_prefix <= ir == CB_PREFIX_OPCODE && !cb_prefix;
                        end
                    end else
                        mcycle <= cond_fail ? last_idx : mcycle + MW'(1);
                end
                S_HALT: begin
                    if (irq_pending) begin
                        ir        <= opcode_in;
                        cb_prefix <= 1'b0;
                        state     <= S_EXEC;
                    end
                end
                default: state <= S_BOOT;
            endcase
        end

endmodule
